// File: rtl/sprite_motion_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_motion_ctrl_pkg : shared screen/sprite geometry and encodings  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sprite_motion_ctrl_pkg;

  localparam int c_screen_w = 96;
  localparam int c_screen_h = 64;
  localparam int c_spr_w    = 18;
  localparam int c_spr_h    = 9;
  localparam int c_xmax     = c_screen_w - c_spr_w;
  localparam int c_ymax     = c_screen_h - c_spr_h;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    AX_HOLD   = 2'd0,
    AX_INC    = 2'd1,
    AX_DEC    = 2'd2,
    AX_BOUNCE = 2'd3
  } axis_mode_e;

endpackage
`default_nettype wire

// File: rtl/sprite_motion_ctrl_axis_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_axis_step : one-axis clamp (manual) / bounce (auto) stepper    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sprite_axis_step
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int LIMIT = c_xmax
) (
  input  logic [6:0]  pos,
  input  logic [2:0]  step,
  input  logic        dir,
  input  axis_mode_e  mode,
  output logic [6:0]  next_pos,
  output logic        next_dir
);

  logic [7:0] sum;
  logic [7:0] step8;
  logic [7:0] pos8;
  logic [7:0] lim8;

  assign step8 = {5'b0, step};
  assign pos8  = {1'b0, pos};
  assign sum   = pos8 + step8;
  assign lim8  = 8'(LIMIT);

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    case (mode)
      AX_INC: next_pos = (sum > lim8) ? lim8[6:0] : sum[6:0];
      AX_DEC: next_pos = (step8 > pos8) ? 7'd0 : (pos - {4'b0, step});
      AX_BOUNCE: begin
        // A zero step must not trip the reach-limit test and flip the flag.
        if (step != 3'd0) begin
          if (dir) begin
            if (sum >= lim8) begin
              next_pos = lim8[6:0];
              next_dir = 1'b0;
            end else begin
              next_pos = sum[6:0];
            end
          end else begin
            if (step8 >= pos8) begin
              next_pos = 7'd0;
              next_dir = 1'b1;
            end else begin
              next_pos = pos - {4'b0, step};
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_motion_ctrl : frame-locked sprite position FSM (manual/bounce) |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int SCREEN_W  = c_screen_w,
  parameter int SCREEN_H  = c_screen_h,
  parameter int SPR_W     = c_spr_w,
  parameter int SPR_H     = c_spr_h,
  parameter int FRAME_DIV = 2,
  parameter int INIT_X    = 39,
  parameter int INIT_Y    = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        mode_auto,
  input  logic [2:0]  step,
  output logic [6:0]  x,
  output logic [6:0]  y,
  output logic        frame_tick,
  output logic        moving
);

  localparam int          c_lim_x    = SCREEN_W - SPR_W;
  localparam int          c_lim_y    = SCREEN_H - SPR_H;
  localparam logic [12:0] c_last_idx = 13'(SCREEN_W * SCREEN_H - 1);
  localparam logic [3:0]  c_div_last = 4'(FRAME_DIV - 1);

  logic [12:0] prev_idx_q, prev_idx_d;
  logic        frame_tick_q, frame_tick_d;
  logic [3:0]  div_q, div_d;
  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;

  logic        step_frame;
  logic        any_btn;
  axis_mode_e  x_mode, y_mode;
  logic [6:0]  x_next, y_next;
  logic        dx_next, dy_next;

  assign step_frame = frame_tick_q && (div_q == 4'd0);
  assign any_btn    = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    state_d = state_q;
    if (step_frame) begin
      if (mode_auto)    state_d = ST_AUTO;
      else if (any_btn) state_d = ST_MANUAL;
      else              state_d = ST_IDLE;
    end
  end

  // Axis behaviour follows the state being entered in this step frame.
  always_comb begin
    x_mode = AX_HOLD;
    y_mode = AX_HOLD;
    case (state_d)
      ST_MANUAL: begin
        if (btn_right && !btn_left)      x_mode = AX_INC;
        else if (btn_left && !btn_right) x_mode = AX_DEC;
        if (btn_down && !btn_up)         y_mode = AX_INC;
        else if (btn_up && !btn_down)    y_mode = AX_DEC;
      end
      ST_AUTO: begin
        x_mode = AX_BOUNCE;
        y_mode = AX_BOUNCE;
      end
      default: ;
    endcase
  end

  sprite_axis_step #(.LIMIT(c_lim_x)) u_step_x (
    .pos      (x_q),
    .step     (step),
    .dir      (dx_q),
    .mode     (x_mode),
    .next_pos (x_next),
    .next_dir (dx_next)
  );

  sprite_axis_step #(.LIMIT(c_lim_y)) u_step_y (
    .pos      (y_q),
    .step     (step),
    .dir      (dy_q),
    .mode     (y_mode),
    .next_pos (y_next),
    .next_dir (dy_next)
  );

  always_comb begin
    prev_idx_d   = pixel_index;
    frame_tick_d = (prev_idx_q == c_last_idx) && (pixel_index == 13'd0);
    div_d        = div_q;
    x_d          = x_q;
    y_d          = y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    if (frame_tick_q) begin
      div_d = (div_q >= c_div_last) ? 4'd0 : div_q + 4'd1;
    end
    if (step_frame) begin
      x_d  = x_next;
      y_d  = y_next;
      dx_d = dx_next;
      dy_d = dy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_idx_q   <= 13'd0;
      frame_tick_q <= 1'b0;
      div_q        <= 4'd0;
      state_q      <= ST_IDLE;
      x_q          <= 7'(INIT_X);
      y_q          <= 7'(INIT_Y);
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
    end else begin
      prev_idx_q   <= prev_idx_d;
      frame_tick_q <= frame_tick_d;
      div_q        <= div_d;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign frame_tick = frame_tick_q;
  assign moving     = (state_q == ST_MANUAL) || (state_q == ST_AUTO);

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_motion_ctrl : directed self-checking bench                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] pixel_index;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        mode_auto;
  logic [2:0]  step;
  logic [6:0]  x, y;
  logic        frame_tick, moving;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_index (pixel_index),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .mode_auto   (mode_auto),
    .step        (step),
    .x           (x),
    .y           (y),
    .frame_tick  (frame_tick),
    .moving      (moving)
  );

  task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixel_index = 13'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Short synthetic frame: last index, wrap to 0, then a few pixels.
  task automatic run_frame();
    @(negedge clk) pixel_index = 13'd6143;
    @(negedge clk) pixel_index = 13'd0;
    @(negedge clk);
    total++;
    if (frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL frame_tick_high: got %b need 1", frame_tick);
    end
    pixel_index = 13'd1;
    @(negedge clk);
    total++;
    if (frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL frame_tick_low: got %b need 0", frame_tick);
    end
    pixel_index = 13'd2;
  endtask

  // One step frame followed by one non-step frame (FRAME_DIV=2).
  task automatic step_pair(input string name, input int ex, input int ey, input logic em);
    run_frame();
    total++;
    if (x !== 7'(ex) || y !== 7'(ey) || moving !== em) begin
      bad++;
      $display("FAIL %s step: got x=%0d y=%0d mv=%b need x=%0d y=%0d mv=%b",
               name, x, y, moving, ex, ey, em);
    end
    run_frame();
    total++;
    if (x !== 7'(ex) || y !== 7'(ey)) begin
      bad++;
      $display("FAIL %s hold: got x=%0d y=%0d need x=%0d y=%0d", name, x, y, ex, ey);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (x !== 7'd39 || y !== 7'd27 || frame_tick !== 1'b0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset: got x=%0d y=%0d ft=%b mv=%b need 39 27 0 0", x, y, frame_tick, moving);
    end
  endtask

  task automatic test_sweep();
    int ticks;
    do_reset();
    ticks = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 6144; i++) begin
        @(negedge clk);
        if (frame_tick === 1'b1) ticks++;
        pixel_index = 13'(i);
      end
    end
    @(negedge clk);
    if (frame_tick === 1'b1) ticks++;
    pixel_index = 13'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
      pixel_index = 13'(100 + i);
    end
    total++;
    if (ticks != 2) begin
      bad++;
      $display("FAIL sweep_ticks: got %0d need 2", ticks);
    end
    total++;
    if (x !== 7'd39 || y !== 7'd27 || moving !== 1'b0) begin
      bad++;
      $display("FAIL sweep_idle: got x=%0d y=%0d mv=%b need 39 27 0", x, y, moving);
    end
    // Non-sequential jumps that are not last->0 must not tick.
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
      case (i)
        0: pixel_index = 13'd6143;
        1: pixel_index = 13'd5;
        2: pixel_index = 13'd0;
        3: pixel_index = 13'd6142;
        4: pixel_index = 13'd0;
        default: pixel_index = 13'd7;
      endcase
    end
    @(negedge clk);
    if (frame_tick === 1'b1) ticks++;
    total++;
    if (ticks != 0) begin
      bad++;
      $display("FAIL jump_no_tick: got %0d need 0", ticks);
    end
  endtask

  task automatic test_manual_right();
    int ex;
    do_reset();
    set_btns(0, 0, 0, 1);
    step = 3'd4;
    ex = 39;
    for (int k = 0; k < 11; k++) begin
      ex = (ex + 4 > 78) ? 78 : ex + 4;
      step_pair("right", ex, 27, 1'b1);
    end
    set_btns(0, 0, 0, 0);
  endtask

  task automatic test_opposite_up();
    int ey;
    do_reset();
    set_btns(1, 0, 1, 1);
    step = 3'd3;
    ey = 27;
    for (int k = 0; k < 9; k++) begin
      ey = ey - 3;
      step_pair("up", 39, ey, 1'b1);
    end
    set_btns(0, 1, 1, 1);
    step = 3'd2;
    step_pair("down2", 39, 2, 1'b1);
    set_btns(1, 0, 1, 1);
    step = 3'd3;
    step_pair("up_clamp", 39, 0, 1'b1);
    set_btns(0, 0, 0, 0);
  endtask

  task automatic test_auto_bounce();
    do_reset();
    mode_auto = 1'b0;
    set_btns(0, 1, 0, 1);
    step = 3'd7;
    step_pair("pos_a", 46, 34, 1'b1);
    step_pair("pos_b", 53, 41, 1'b1);
    step_pair("pos_c", 60, 48, 1'b1);
    step = 3'd2;
    step_pair("pos_d", 62, 50, 1'b1);
    set_btns(0, 0, 0, 1);
    step = 3'd7;
    step_pair("pos_e", 69, 50, 1'b1);
    step = 3'd1;
    step_pair("pos_f", 70, 50, 1'b1);
    set_btns(0, 0, 0, 0);
    mode_auto = 1'b1;
    step = 3'd7;
    step_pair("auto1", 77, 55, 1'b1);
    step_pair("auto2", 78, 48, 1'b1);
    step_pair("auto3", 71, 41, 1'b1);
    step = 3'd0;
    step_pair("auto_step0", 71, 41, 1'b1);
  endtask

  task automatic test_reset_in_step();
    // Continues from test_auto_bounce: AUTO, dx=dy=0 at (71,41).
    step = 3'd7;
    @(negedge clk) pixel_index = 13'd6143;
    @(negedge clk) pixel_index = 13'd0;
    @(negedge clk);
    reset = 1'b1;
    pixel_index = 13'd1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (x !== 7'd39 || y !== 7'd27 || moving !== 1'b0 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_step: got x=%0d y=%0d mv=%b ft=%b need 39 27 0 0",
               x, y, moving, frame_tick);
    end
    step = 3'd1;
    step_pair("flags_reset", 40, 28, 1'b1);
    mode_auto = 1'b0;
  endtask

  task automatic test_auto_priority();
    do_reset();
    mode_auto = 1'b1;
    set_btns(0, 1, 0, 0);
    step = 3'd1;
    step_pair("auto_prio", 40, 28, 1'b1);
    mode_auto = 1'b0;
    set_btns(0, 0, 0, 0);
    step_pair("to_idle", 40, 28, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    pixel_index = 13'd0;
    set_btns(0, 0, 0, 0);
    mode_auto = 1'b0;
    step = 3'd0;
    test_reset();
    test_sweep();
    test_manual_right();
    test_opposite_up();
    test_auto_bounce();
    test_reset_in_step();
    test_auto_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
